// File: rtl/f_le_rr_arbiter_if.sv
// Request/response bundle between N_REQ compare requesters and the shared
// f_le arbiter. Operand width comes from the shared F_LE_FLEN config macro
// (64 = FP64 when not set elsewhere).
`ifndef F_LE_FLEN
`define F_LE_FLEN 64
`endif

interface f_le_rr_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int FLEN = `F_LE_FLEN;

   logic [N_REQ-1:0]           req_valid;
   logic [N_REQ-1:0]           req_ready;
   logic [N_REQ-1:0][FLEN-1:0] req_a;
   logic [N_REQ-1:0][FLEN-1:0] req_b;
   logic [N_REQ-1:0]           resp_valid;
   logic [N_REQ-1:0]           resp_ready;
   logic                       resp_res;
   logic                       resp_err;

   // Requester side
   modport master (
      output req_valid, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_res, resp_err
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_res, resp_err
   );
endinterface

// File: rtl/f_le_rr_arbiter.sv
// Round-robin arbiter sharing one combinational f_less_or_equal comparator
// among N_REQ requesters. One compare in flight: IDLE accepts the winner,
// CMP captures the comparator result, RESP holds it until the granted
// requester accepts it.
// Optional: define F_LE_RR_ARBITER_STATS_EN to add saturating cnt_cmp /
// cnt_err handshake counters as extra output ports.
`ifndef F_LE_FLEN
`define F_LE_FLEN 64
`endif

module f_le_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   f_le_rr_arbiter_if.slave       bus,
   output logic [ID_W-1:0]        grant_id,
   output logic                   busy,
   output logic [`F_LE_FLEN-1:0]  f_le_a,
   output logic [`F_LE_FLEN-1:0]  f_le_b,
   input  logic                   f_le_res,
   input  logic                   f_le_err
`ifdef F_LE_RR_ARBITER_STATS_EN
   ,
   output logic [15:0]            cnt_cmp,
   output logic [15:0]            cnt_err
`endif
);
   localparam int FLEN = `F_LE_FLEN;

   typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [FLEN-1:0]   a_q, a_d;
   logic [FLEN-1:0]   b_q, b_d;
   logic              res_q, res_d;
   logic              err_q, err_d;

   logic              any_req;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   cand;
   logic              resp_hs;

`ifdef F_LE_RR_ARBITER_STATS_EN
   logic [15:0]       cnt_cmp_q, cnt_cmp_d;
   logic [15:0]       cnt_err_q, cnt_err_d;
`endif

   // Round-robin pick: first valid requester at or after last_grant+1, wrapping.
   // Scanning from the far end lets the nearest candidate overwrite the rest.
   always_comb begin
      any_req = 1'b0;
      winner  = '0;
      cand    = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = ID_W'((int'(last_grant_q) + k) % N_REQ);
         if (bus.req_valid[cand]) begin
            any_req = 1'b1;
            winner  = cand;
         end
      end
   end

   assign resp_hs = (state_q == RESP) && bus.resp_ready[grant_id_q];

   // Next-state and handshake strobes; req_ready is suppressed during reset so
   // no requester believes its request was taken while the arbiter clears.
   always_comb begin
      state_d        = state_q;
      grant_id_d     = grant_id_q;
      last_grant_d   = last_grant_q;
      a_d            = a_q;
      b_d            = b_q;
      res_d          = res_q;
      err_d          = err_q;
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               bus.req_ready[winner] = ~rst;
               a_d        = bus.req_a[winner];
               b_d        = bus.req_b[winner];
               grant_id_d = winner;
               state_d    = CMP;
            end
         end
         CMP: begin
            res_d   = f_le_res;
            err_d   = f_le_err;
            state_d = RESP;
         end
         RESP: begin
            bus.resp_valid[grant_id_q] = 1'b1;
            if (resp_hs) begin
               last_grant_d = grant_id_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef F_LE_RR_ARBITER_STATS_EN
   // Saturating counters of completed response handshakes and of NaN results.
   always_comb begin
      cnt_cmp_d = cnt_cmp_q;
      cnt_err_d = cnt_err_q;
      if (resp_hs && cnt_cmp_q != 16'hFFFF) cnt_cmp_d = cnt_cmp_q + 16'd1;
      if (resp_hs && err_q && cnt_err_q != 16'hFFFF) cnt_err_d = cnt_err_q + 16'd1;
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_cmp_q <= '0;
         cnt_err_q <= '0;
      end else begin
         cnt_cmp_q <= cnt_cmp_d;
         cnt_err_q <= cnt_err_d;
      end
   end

   assign cnt_cmp = cnt_cmp_q;
   assign cnt_err = cnt_err_q;
`endif

   // State, operand and result registers; reset priority pointer so that
   // requester 0 is searched first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         last_grant_q <= ID_W'(N_REQ - 1);
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         res_q        <= res_d;
         err_q        <= err_d;
      end
   end

   assign grant_id     = grant_id_q;
   assign busy         = (state_q != IDLE);
   assign f_le_a       = a_q;
   assign f_le_b       = b_q;
   assign bus.resp_res = res_q;
   assign bus.resp_err = err_q;

endmodule

// File: tb/tb_f_le_rr_arbiter.sv
// Directed bench for f_le_rr_arbiter with a behavioural FP64 <= comparator
// and a queue of expected responses.
module tb_f_le_rr_arbiter;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  grant_id;
   logic        busy;
   logic [63:0] f_le_a, f_le_b;
   logic        f_le_res, f_le_err;
`ifdef F_LE_RR_ARBITER_STATS_EN
   logic [15:0] cnt_cmp, cnt_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int   id;
      logic res;
      logic err;
   } exp_t;
   exp_t sb[$];

   localparam logic [63:0] ONE  = 64'h3FF0000000000000;
   localparam logic [63:0] TWO  = 64'h4000000000000000;
   localparam logic [63:0] NAN  = 64'h7FF8000000000000;
   localparam logic [63:0] ZERO = 64'h0000000000000000;
   localparam logic [63:0] M35  = 64'hC00C000000000000;

   f_le_rr_arbiter_if #(.N_REQ(N)) bus ();

   f_le_rr_arbiter #(.N_REQ(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .grant_id (grant_id),
      .busy     (busy),
      .f_le_a   (f_le_a),
      .f_le_b   (f_le_b),
      .f_le_res (f_le_res),
      .f_le_err (f_le_err)
`ifdef F_LE_RR_ARBITER_STATS_EN
      ,
      .cnt_cmp  (cnt_cmp),
      .cnt_err  (cnt_err)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural FP64 a <= b; NaN operand flags err and forces res low.
   function automatic logic [1:0] fle(input logic [63:0] a, input logic [63:0] b);
      logic nan_a, nan_b, r;
      nan_a = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
      nan_b = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
      if (nan_a || nan_b)                     r = 1'b0;
      else if (a[62:0] == 63'd0 && b[62:0] == 63'd0) r = 1'b1;
      else if (a[63] != b[63])                r = a[63];
      else if (!a[63])                        r = (a[62:0] <= b[62:0]);
      else                                    r = (a[62:0] >= b[62:0]);
      return {nan_a | nan_b, r};
   endfunction

   always_comb {f_le_err, f_le_res} = fle(f_le_a, f_le_b);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   // Compare the response presented in this cycle against the oldest expectation.
   task automatic check_resp();
      exp_t e;
      logic [3:0] oh;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL sb_empty: observed resp_valid %0h expected no response", bus.resp_valid);
         return;
      end
      e  = sb.pop_front();
      oh = 4'b0001 << e.id;
      chk("resp_valid", 64'(bus.resp_valid), 64'(oh));
      chk("resp_grant", 64'(grant_id), 64'(e.id));
      chk("resp_res", 64'(bus.resp_res), 64'(e.res));
      chk("resp_err", 64'(bus.resp_err), 64'(e.err));
   endtask

   initial begin
      logic [3:0] oh;
      logic       er [N];
      logic       ee [N];
      int         id;

      rst            = 1'b1;
      bus.req_valid  = '0;
      bus.resp_ready = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      repeat (3) tick();
      rst = 1'b0;
      settle();

      // Reset values
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_res", 64'(bus.resp_res), 64'd0);
      chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
      chk("rst_grant_id", 64'(grant_id), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_f_le_a", f_le_a, 64'd0);
      chk("rst_f_le_b", f_le_b, 64'd0);

      // Single request from requester 1: 1.0 <= 2.0
      bus.req_valid  = 4'b0010;
      bus.req_a[1]   = ONE;
      bus.req_b[1]   = TWO;
      bus.resp_ready = 4'hF;
      settle();
      chk("single_req_ready", 64'(bus.req_ready), 64'h2);
      sb.push_back('{id: 1, res: 1'b1, err: 1'b0});
      tick();
      bus.req_valid = '0;
      settle();
      chk("single_busy", 64'(busy), 64'd1);
      chk("single_cmp_ready", 64'(bus.req_ready), 64'd0);
      chk("single_f_le_a", f_le_a, ONE);
      chk("single_f_le_b", f_le_b, TWO);
      tick();
      check_resp();
      tick();
      chk("single_resp_drop", 64'(bus.resp_valid), 64'd0);
      chk("single_idle", 64'(busy), 64'd0);

      // Contention: all four requesters valid continuously after reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req_a[0] = ONE;  bus.req_b[0] = TWO;  er[0] = 1'b1; ee[0] = 1'b0;
      bus.req_a[1] = TWO;  bus.req_b[1] = ONE;  er[1] = 1'b0; ee[1] = 1'b0;
      bus.req_a[2] = NAN;  bus.req_b[2] = ZERO; er[2] = 1'b0; ee[2] = 1'b1;
      bus.req_a[3] = M35;  bus.req_b[3] = M35;  er[3] = 1'b1; ee[3] = 1'b0;
      bus.req_valid  = 4'hF;
      bus.resp_ready = 4'hF;
      settle();
`ifdef F_LE_RR_ARBITER_STATS_EN
      chk("stats_rst_cmp", 64'(cnt_cmp), 64'd0);
      chk("stats_rst_err", 64'(cnt_err), 64'd0);
`endif
      for (int g = 0; g < 5; g++) begin
         id = g % N;
         oh = 4'b0001 << id;
         chk("rr_grant", 64'(bus.req_ready), 64'(oh));
         sb.push_back('{id: id, res: er[id], err: ee[id]});
         tick();
         tick();
         check_resp();
         tick();
         settle();
`ifdef F_LE_RR_ARBITER_STATS_EN
         if (g == 2) begin
            chk("stats_cmp", 64'(cnt_cmp), 64'd3);
            chk("stats_err", 64'(cnt_err), 64'd1);
         end
`endif
      end

      // Back-pressure on requester 1; other requesters' resp_ready are high
      bus.resp_ready = 4'b1101;
      settle();
      chk("bp_grant", 64'(bus.req_ready), 64'h2);
      sb.push_back('{id: 1, res: 1'b0, err: 1'b0});
      tick();
      tick();
      check_resp();
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_resp_valid", 64'(bus.resp_valid), 64'h2);
         chk("bp_resp_res", 64'(bus.resp_res), 64'd0);
         chk("bp_resp_err", 64'(bus.resp_err), 64'd0);
         chk("bp_grant_id", 64'(grant_id), 64'd1);
         chk("bp_no_accept", 64'(bus.req_ready), 64'd0);
      end
      bus.resp_ready = 4'hF;
      tick();
      settle();
      chk("bp_resp_drop", 64'(bus.resp_valid), 64'd0);
      chk("bp_next_grant", 64'(bus.req_ready), 64'h4);

      // Reset while requester 2's compare is in CMP
      tick();
      settle();
      chk("mid_busy", 64'(busy), 64'd1);
      chk("mid_grant_id", 64'(grant_id), 64'd2);
      rst = 1'b1;
      tick();
      settle();
      chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("mid_rst_resp_res", 64'(bus.resp_res), 64'd0);
      chk("mid_rst_resp_err", 64'(bus.resp_err), 64'd0);
      chk("mid_rst_grant_id", 64'(grant_id), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_f_le_a", f_le_a, 64'd0);
      chk("mid_rst_f_le_b", f_le_b, 64'd0);
      rst = 1'b0;
      bus.req_valid = 4'b1001;
      settle();
      chk("post_rst_grant0", 64'(bus.req_ready), 64'h1);
      sb.push_back('{id: 0, res: 1'b1, err: 1'b0});
      tick();
      chk("post_rst_no_resp", 64'(bus.resp_valid), 64'd0);
      tick();
      check_resp();
      tick();
      settle();
      chk("post_rst_grant3", 64'(bus.req_ready), 64'h8);
      sb.push_back('{id: 3, res: 1'b1, err: 1'b0});
      tick();
      tick();
      check_resp();
      tick();
      bus.req_valid = '0;
      settle();
      chk("final_idle", 64'(busy), 64'd0);
      chk("final_sb_drained", 64'(sb.size()), 64'd0);
`ifdef F_LE_RR_ARBITER_STATS_EN
      chk("stats_final_cmp", 64'(cnt_cmp), 64'd2);
      chk("stats_final_err", 64'(cnt_err), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/f_le_rr_arbiter.md
Name: f_le_rr_arbiter

Overview:
- Shares one combinational f_less_or_equal comparator among N_REQ requesters, e.g. several sort FSMs or min/max units.
- Accepts one compare request at a time, chosen round-robin, and drives the comparator operands from registers.
- Captures res/err and returns them to the granted requester over a valid/ready response channel.
- Sits between the requesters and the single comparator instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of the grant index.
- FLEN: not a parameter. It comes from the shared config include (64 = FP64).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  N_REQ  per-requester compare request.
- req_ready  out  N_REQ  one-hot accept strobe, combinational.
- req_a  in  N_REQ x FLEN  operand a per requester.
- req_b  in  N_REQ x FLEN  operand b per requester.
- resp_valid  out  N_REQ  one-hot response valid.
- resp_ready  in  N_REQ  per-requester response accept.
- resp_res  out  1  captured f_le_res (a <= b).
- resp_err  out  1  captured f_le_err (NaN operand).
- grant_id  out  ID_W  index of the requester currently owning the comparator.
- busy  out  1  high when state != IDLE.
- f_le_a  out  FLEN  comparator operand a, registered.
- f_le_b  out  FLEN  comparator operand b, registered.
- f_le_res  in  1  comparator result.
- f_le_err  in  1  comparator error.

Behaviour:
- Reset values: state=IDLE, req_ready=0, resp_valid=0, resp_res=0, resp_err=0, grant_id=0, f_le_a=0, f_le_b=0, busy=0.
- Reset sets the priority pointer so that requester 0 has top priority.
- States are IDLE, CMP and RESP.
- IDLE, arbitration:
  - If any req_valid is set, pick the winner: the first set bit searching upward from (last_grant+1) mod N_REQ, wrapping.
  - req_ready[winner]=1 in that same cycle only; the request is transferred.
  - On the clock edge: f_le_a<=req_a[winner], f_le_b<=req_b[winner], grant_id<=winner, go to CMP.
  - With no requests, stay in IDLE and hold all req_ready=0.
- CMP:
  - The comparator sees the registered operands.
  - resp_res<=f_le_res, resp_err<=f_le_err, go to RESP.
  - req_ready=0.
- RESP:
  - resp_valid[grant_id]=1; all other bits are 0.
  - resp_res and resp_err are held stable.
  - When resp_ready[grant_id]=1: last_grant<=grant_id, resp_valid goes 0 on the next cycle, return to IDLE.
  - resp_ready bits of other requesters are ignored.
  - Back-pressure may last indefinitely; no new request is accepted meanwhile.
- Timing:
  - Latency: accept at cycle T, resp_valid high at T+2.
  - Minimum issue interval is 3 cycles; the next accept can be in the IDLE cycle after the response handshake.
- req_a/req_b are sampled only in the accept cycle and may change afterwards.
- A requester may drop req_valid before it is granted; no state is kept for it.
- A lone requester is granted every round; no starvation with N_REQ requesters, each waits at most N_REQ-1 grants.
- f_le_a/f_le_b hold their last values outside CMP; they are not cleared.
- Reset mid-operation, in any state:
  - The pending response is discarded and never presented; everything returns to reset values.
  - The requester must reissue the request.
- Simultaneous req_valid from the requester currently in RESP is not accepted until IDLE.

Optional Feature:
- Macro: F_LE_RR_ARBITER_STATS_EN.
- When defined, two extra output ports are added:
  - cnt_cmp (16 bits): saturating count of completed response handshakes.
  - cnt_err (16 bits): saturating count of completed handshakes with resp_err=1.
  - Both are cleared by rst and saturate at 16'hFFFF.
- When undefined, the ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Single request: req 1 valid, a=1.0 (0x3FF0000000000000), b=2.0 (0x4000000000000000), resp_ready tied 1.
  - req_ready[1] is high in cycle T.
  - resp_valid=4'b0010 with res=1, err=0 at T+2, low at T+3.
- Contention: all four req_valid held high continuously after reset.
  - Grant order is 0,1,2,3,0, each grant exactly 3 cycles apart.
- NaN: a=0x7FF8000000000000, b=0.0 -> resp_err=1.
- Back-pressure: resp_ready low for 5 cycles.
  - resp_valid, resp_res, resp_err and grant_id stay stable.
  - No other requester gets req_ready; after accept, the next grant goes to the next requester in round-robin order.
- Reset mid-op: assert rst in the CMP state.
  - Next cycle all outputs are at reset values and resp_valid is never raised for that request.
  - A subsequent request from requester 3 with requester 0 also valid grants requester 0 first.
- Equality and stats: a=b=-3.5 gives res=1.
  - With F_LE_RR_ARBITER_STATS_EN defined, after 3 compares including 1 NaN: cnt_cmp=3, cnt_err=1.
